// File: rtl/prog_rom_pkg.sv
// Shared types and default widths for the program ROM arbiter and its checksum scanner.
package prog_rom_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 18;
  localparam int DEPTH_DEF        = 1024;
  localparam int DBG_MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {G_NONE, G_CPU, G_DBG, G_SCAN} grant_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} scan_state_t;

endpackage

// File: rtl/prog_rom_scanner.sv
// Checksum scanner: walks the ROM address space through the arbiter and sums the
// returned words modulo 2^DATA_W.
module prog_rom_scanner
  import prog_rom_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              grant,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_data,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end

  // Returns lag issues by one cycle, so the final word is folded in during DRAIN.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = ret_valid ? acc_q + ret_data : acc_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      S_SCAN: begin
        if (grant) begin
          addr_d = addr_q + CNT_W'(1);
          if (addr_q == CNT_W'(DEPTH - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        sum_d   = acc_d;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req  = (state_q == S_SCAN) && (addr_q < CNT_W'(DEPTH));
    addr = ADDR_W'(addr_q);
    busy = (state_q == S_SCAN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
    sum  = sum_q;
  end

endmodule

// File: rtl/prog_rom_arbiter.sv
// Three-way arbiter for the synchronous program ROM: CPU fetch, debug reads and the
// checksum scanner, with tag-based routing of the one-cycle-late read data.
module prog_rom_arbiter
  import prog_rom_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_EN,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [DATA_W-1:0] CPU_IR,
  output logic              CPU_STALL,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_DATA,
  input  logic              SCAN_START,
  output logic              SCAN_BUSY,
  output logic              SCAN_DONE,
  output logic [DATA_W-1:0] SCAN_SUM,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_IR
);

  localparam int                WAIT_W   = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

  grant_t            grant, tag_q, tag_d, ret_tag;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] cpu_ir_q, cpu_ir_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_ok, forced;
  logic              scan_req, scan_busy, scan_done;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_sum;

  prog_rom_scanner #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_scanner (
    .clk       (CLK),
    .rst       (RST),
    .start     (SCAN_START),
    .grant     (grant == G_SCAN),
    .ret_valid (ret_tag == G_SCAN),
    .ret_data  (ROM_IR),
    .req       (scan_req),
    .addr      (scan_addr),
    .busy      (scan_busy),
    .done      (scan_done),
    .sum       (scan_sum)
  );

  // A debug read already in flight blocks both a re-grant and the starvation force.
  always_comb begin
    dbg_ok = DBG_REQ && (tag_q != G_DBG);
    forced = dbg_ok && (wait_q == WAIT_MAX);
    grant  = G_NONE;
    if (RST)                   grant = G_NONE;
    else if (CPU_EN && !forced) grant = G_CPU;
    else if (dbg_ok)           grant = G_DBG;
    else if (scan_req)         grant = G_SCAN;
  end

  always_comb begin
    case (grant)
      G_CPU:   ROM_ADDR = CPU_ADDR;
      G_DBG:   ROM_ADDR = DBG_ADDR;
      G_SCAN:  ROM_ADDR = scan_addr;
      default: ROM_ADDR = '0;
    endcase
    CPU_STALL = CPU_EN && !RST && (grant != G_CPU);
  end

  // Reset drops whatever read is returning this cycle.
  always_comb begin
    ret_tag    = RST ? G_NONE : tag_q;
    tag_d      = grant;
    cpu_ir_d   = (ret_tag == G_CPU) ? ROM_IR : cpu_ir_q;
    dbg_data_d = (ret_tag == G_DBG) ? ROM_IR : dbg_data_q;
    wait_d     = wait_q;
    if (!DBG_REQ || grant == G_DBG)        wait_d = '0;
    else if (dbg_ok && wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q      <= G_NONE;
      wait_q     <= '0;
      cpu_ir_q   <= '0;
      dbg_data_q <= '0;
    end else begin
      tag_q      <= tag_d;
      wait_q     <= wait_d;
      cpu_ir_q   <= cpu_ir_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    CPU_IR    = RST ? '0 : cpu_ir_d;
    DBG_ACK   = (ret_tag == G_DBG);
    DBG_DATA  = RST ? '0 : dbg_data_d;
    SCAN_BUSY = scan_busy && !RST;
    SCAN_DONE = scan_done && !RST;
    SCAN_SUM  = RST ? '0 : scan_sum;
  end

endmodule

// File: doc/prog_rom_arbiter.md
Name: prog_rom_arbiter

Overview:
- Shares the single synchronous 1024x18 program ROM between three requesters.
- Requesters, in priority order: CPU instruction fetch, debug read port (UART monitor), built-in checksum scanner.
- Owns the ROM address mux and tags each issued read, so the 1-cycle-later data routes back to its issuer.
- Inserts CPU stalls only when the debug starvation guard forces a debug slot.

Parameters:
- ADDR_W, 10, ROM address width.
- DATA_W, 18, ROM word width.
- DEPTH, 1024, words covered by the checksum scan.
- DBG_MAX_WAIT, 8, max consecutive cycles a pending debug request may lose to the CPU before it is forced through.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- CPU_EN  in  1  CPU fetch request this cycle.
- CPU_ADDR  in  ADDR_W  CPU fetch address.
- CPU_IR  out  DATA_W  instruction returned to CPU.
- CPU_STALL  out  1  CPU fetch not issued this cycle; CPU must hold CPU_ADDR.
- DBG_REQ  in  1  debug read request, level, held until DBG_ACK.
- DBG_ADDR  in  ADDR_W  debug address; stable while DBG_REQ is high.
- DBG_ACK  out  1  one-cycle pulse; DBG_DATA valid.
- DBG_DATA  out  DATA_W  debug read data.
- SCAN_START  in  1  start checksum scan (pulse).
- SCAN_BUSY  out  1  scan in progress.
- SCAN_DONE  out  1  one-cycle pulse at scan completion.
- SCAN_SUM  out  DATA_W  checksum result.
- ROM_ADDR  out  ADDR_W  address to ROM.
- ROM_IR  in  DATA_W  ROM data, valid 1 cycle after ROM_ADDR.

Behaviour:
- Reset values: all outputs 0; tag=NONE; scan FSM=IDLE; wait counter=0; SCAN_SUM=0.
- Reset mid-operation discards any in-flight return: no DBG_ACK, no accumulation.
- Grant (combinational, per cycle):
  - CPU if CPU_EN and not forced;
  - else DBG if DBG_REQ and no debug read in flight;
  - else SCAN if FSM=SCAN and scan address < DEPTH;
  - else NONE.
- Forced: DBG_REQ high and wait counter == DBG_MAX_WAIT. Debug wins that cycle.
- ROM_ADDR = granted requester's address; 0 when NONE.
- CPU_STALL = CPU_EN and grant != CPU (combinational).
- Tag register captures grant each cycle; returned data is routed by the tag in the following cycle.
- CPU path:
  - CPU_IR = ROM_IR when tag==CPU; otherwise the held last CPU word.
  - Latency 1 cycle, identical to a direct ROM connection when not stalled.
- Wait counter:
  - increments while DBG_REQ is high and debug loses;
  - clears on debug grant or when DBG_REQ is low;
  - saturates at DBG_MAX_WAIT.
- DBG path:
  - tag==DBG: DBG_ACK=1 and DBG_DATA<=ROM_IR, held until the next ack.
  - At most one debug read in flight; no re-grant in the ack cycle.
  - DBG_REQ dropped before grant: request abandoned.
  - DBG_REQ dropped after grant: ack still pulses.
- Scan FSM:
  - IDLE: SCAN_START -> SCAN; scan address=0; sum=0; SCAN_BUSY=1.
  - SCAN: each scan grant increments the address. Tag==SCAN returns add ROM_IR into sum, modulo 2^DATA_W (wrap, no carry-out). After address DEPTH-1 issues -> DRAIN.
  - DRAIN: wait one cycle for the last return -> DONE.
  - DONE: SCAN_SUM<=sum; SCAN_DONE=1 for one cycle; SCAN_BUSY=0; -> IDLE.
  - SCAN_START while not IDLE is ignored.
  - SCAN_SUM holds until the next completion.
- Simultaneous events:
  - CPU and DBG same cycle: CPU wins unless forced.
  - DBG and SCAN same cycle: DBG wins; scan address not advanced.

Decomposition:
- Package prog_rom_pkg holds:
  - typedef enum grant_t {G_NONE, G_CPU, G_DBG, G_SCAN};
  - typedef enum scan_state_t {S_IDLE, S_SCAN, S_DRAIN, S_DONE};
  - ADDR_W/DATA_W defaults.
- One sub-module: prog_rom_scanner, containing the scan FSM, address counter and accumulator. It presents a request/address to the arbiter and consumes returns flagged by the arbiter.

Test Plan:
- CPU only, CPU_EN=1, addresses 0,1,2 vs ROM contents = address+0x100 -> CPU_IR 0x100,0x101,0x102 one cycle after each; CPU_STALL always 0.
- DBG_REQ, DBG_ADDR=0x3FF, CPU_EN=0 -> ROM_ADDR=0x3FF same cycle; DBG_ACK pulse next cycle with DBG_DATA=rom[0x3FF].
- CPU_EN held 1 with DBG_REQ pending, DBG_MAX_WAIT=8 -> debug granted on the 9th cycle; CPU_STALL=1 exactly that cycle; CPU_IR unchanged during the stall.
- ROM filled with 0x3FFFF, SCAN_START, no other traffic -> SCAN_DONE after 1026 cycles; SCAN_SUM=(1024*0x3FFFF) mod 2^18=0x3FC00.
- Scan with interleaved CPU fetches every other cycle -> same SCAN_SUM; scan completion delayed accordingly; SCAN_START mid-scan ignored.
- RST asserted in the cycle after a DBG grant -> no DBG_ACK; all outputs 0; scan FSM IDLE next cycle.
